// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its video-fetch, CPU-write and VRAM-pin neighbours.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface vram_arbiter_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 13
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // seqPhase carries hCount[2:0]; "sequence" is a reserved word in SystemVerilog
    logic [2:0]        seqPhase;
    logic              vidActive;
    logic [ADDR_W-1:0] vidAddr;
    logic [7:0]        vidData;
    logic              vidDataValid;
    logic              wrValid;
    logic              wrReady;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;
    logic [LVL_W-1:0]  fifoLevel;
    logic [ADDR_W-1:0] vramAddr;
    logic [7:0]        vramDataOut;
    logic              vramDataOE;
    logic [7:0]        vramDataIn;
    logic              nvramOE;
    logic              nvramWE;

    modport slave (
        input  seqPhase, vidActive, vidAddr, wrValid, wrAddr, wrData, vramDataIn,
        output vidData, vidDataValid, wrReady, fifoLevel,
               vramAddr, vramDataOut, vramDataOE, nvramOE, nvramWE
    );

    modport master (
        output seqPhase, vidActive, vidAddr, wrValid, wrAddr, wrData, vramDataIn,
        input  vidData, vidDataValid, wrReady, fifoLevel,
               vramAddr, vramDataOut, vramDataOE, nvramOE, nvramWE
    );
endinterface

// File: rtl/vram_arbiter.sv
// Slot-scheduled arbiter for the shared async VRAM: one video read and one buffered CPU write per 8-pixel slot.
// Optional VRAM_ARB_BLANK_WRITE_EN adds a second write window at slot phase 7 when video is idle.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | no VRAM access; waits for a read (phase 7) or write trigger
//   RD        | nvramOE low for three cycles, data captured on the last edge
//   WR_SETUP  | address and data driven, strobe still high
//   WR_STROBE | nvramWE low
//   WR_HOLD   | strobe released, data still driven; FIFO pops on exit
module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 13
) (
    input  logic          pixClk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } state_t;

    state_t            r_state;
    logic [1:0]        r_rd_cnt;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [7:0]        r_vram_dout;
    logic              r_vram_doe;
    logic              r_noe;
    logic              r_nwe;
    logic [7:0]        r_vid_data;
    logic              r_vid_valid;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rd_start;
    logic w_wr_start;

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = bus.wrValid && !w_full;
    assign w_pop   = (r_state == WR_HOLD);

    assign w_rd_start = (r_state == IDLE) && (bus.seqPhase == 3'd7) && bus.vidActive;
`ifdef VRAM_ARB_BLANK_WRITE_EN
    assign w_wr_start = (r_state == IDLE) && !w_empty &&
                        ((bus.seqPhase == 3'd3) || ((bus.seqPhase == 3'd7) && !bus.vidActive));
`else
    assign w_wr_start = (r_state == IDLE) && !w_empty && (bus.seqPhase == 3'd3);
`endif

    always_ff @(posedge pixClk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.wrAddr;
            r_fifo_data[r_wr_ptr] <= bus.wrData;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge pixClk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge pixClk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_cnt    <= '0;
            r_vram_addr <= '0;
            r_vram_dout <= '0;
            r_vram_doe  <= 1'b0;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_vid_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_rd_start) begin
                        r_state     <= RD;
                        r_vram_addr <= bus.vidAddr;
                        r_noe       <= 1'b0;
                        r_rd_cnt    <= '0;
                    end else if (w_wr_start) begin
                        r_state     <= WR_SETUP;
                        r_vram_addr <= r_fifo_addr[r_rd_ptr];
                        r_vram_dout <= r_fifo_data[r_rd_ptr];
                        r_vram_doe  <= 1'b1;
                    end
                end
                RD: begin
                    if (r_rd_cnt == 2'd2) begin
                        r_vid_data  <= bus.vramDataIn;
                        r_vid_valid <= 1'b1;
                        r_noe       <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 2'd1;
                    end
                end
                WR_SETUP: begin
                    r_nwe   <= 1'b0;
                    r_state <= WR_STROBE;
                end
                WR_STROBE: begin
                    r_nwe   <= 1'b1;
                    r_state <= WR_HOLD;
                end
                WR_HOLD: begin
                    r_vram_doe <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wrReady      = !w_full;
    assign bus.fifoLevel    = r_level;
    assign bus.vramAddr     = r_vram_addr;
    assign bus.vramDataOut  = r_vram_dout;
    assign bus.vramDataOE   = r_vram_doe;
    assign bus.nvramOE      = r_noe;
    assign bus.nvramWE      = r_nwe;
    assign bus.vidData      = r_vid_data;
    assign bus.vidDataValid = r_vid_valid;
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Time-slot arbiter for the single asynchronous 8-bit VRAM shared by the video fetch path and the CPU write-snoop path.
- Uses the 8-pixel slot counter (hCount[2:0]) to schedule one video read and one CPU write window per slot, so the two paths never contend.
- Buffers CPU writes in a small FIFO.
- Owns all VRAM strobes, the VRAM address mux and the data-bus tristate enable; the top level only wires the inout.

Parameters:
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, 2..16.
- ADDR_W, 13, VRAM address width.

Ports:
- pixClk  in  1  25.175 MHz pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sequence  in  3  slot phase, equal to hCount[2:0]; increments every clock.
- vidActive  in  1  video fetch needed for the coming slot; sampled at trigger edge.
- vidAddr  in  ADDR_W  video fetch address; sampled at trigger edge.
- vidData  out  8  fetched byte.
- vidDataValid  out  1  one-cycle pulse; vidData is new.
- wrValid  in  1  CPU write request.
- wrReady  out  1  FIFO not full.
- wrAddr  in  ADDR_W  CPU write address.
- wrData  in  8  CPU write byte.
- fifoLevel  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- vramAddr  out  ADDR_W  VRAM address.
- vramDataOut  out  8  data driven to VRAM.
- vramDataOE  out  1  1 = top level drives vramData from vramDataOut.
- vramDataIn  in  8  VRAM read data.
- nvramOE  out  1  VRAM read strobe, active low.
- nvramWE  out  1  VRAM write strobe, active low.

Behaviour:
- Reset values:
  - nvramOE = 1, nvramWE = 1, vramDataOE = 0.
  - vramAddr = 0, vramDataOut = 0, vidData = 0, vidDataValid = 0.
  - FIFO empty, fifoLevel = 0, wrReady = 1, FSM in IDLE.
- Reset mid-operation: strobes deassert on the next edge and queued writes are discarded.
- All VRAM-side outputs are registered. wrReady is combinational: !full.
- FIFO:
  - Push on a clock edge with wrValid & wrReady.
  - Pop only at the end of WR_HOLD.
  - Push while full is ignored and is a requester protocol error.
  - Push and pop in the same edge keeps the level unchanged.
  - When full, a same-cycle pop does not enable a push; wrReady reflects the pre-edge level.
- FSM states: IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD.
  - Once started, the FSM advances one state per clock regardless of sequence.
  - A sequence value only starts an operation, and only from IDLE.
- Read trigger: edge with sequence == 7 and vidActive = 1.
  - Enter RD, latch vramAddr = vidAddr, nvramOE = 0.
  - RD lasts 3 cycles (sequence 0, 1, 2).
  - At the edge with sequence == 2, capture vramDataIn into vidData.
  - On that edge, also pulse vidDataValid for the next cycle, set nvramOE = 1, and go to IDLE.
- Write trigger: edge with sequence == 3 and FIFO not empty.
  - Load the FIFO head into vramAddr/vramDataOut, set vramDataOE = 1, enter WR_SETUP (sequence 4).
  - Next edge: WR_STROBE, nvramWE = 0 (sequence 5).
  - Next edge: WR_HOLD, nvramWE = 1, data still driven (sequence 6).
  - Next edge: vramDataOE = 0, pop, go to IDLE (sequence 7 is turnaround).
  - Address is stable across the whole write window.
- Cycle rules:
  - nvramOE and nvramWE are never low in the same cycle.
  - vramDataOE is never 1 while nvramOE = 0.
- Without the optional feature: at most one CPU write per 8-cycle slot, whether in active video or blanking.
- vramAddr holds its last value in IDLE.

Optional Feature:
- Macro: VRAM_ARB_BLANK_WRITE_EN.
- Defined: an edge with sequence == 7, vidActive = 0 and FIFO not empty starts a second write window.
  - Phases WR_SETUP/WR_STROBE/WR_HOLD occupy sequence 0, 1, 2; release at the edge with sequence == 2.
  - Sequence 3 is turnaround; the normal window at sequence 3 still follows.
  - Result: up to 2 writes per slot during blanking.
- Undefined: sequence == 7 with vidActive = 0 does nothing; behaviour is exactly as above.

Test Plan:
- Reset held 3 cycles with wrValid = 1 mid-write → strobes high, vramDataOE = 0, fifoLevel = 0, wrReady = 1 after release.
- vidActive = 1, vidAddr = 0x0123, VRAM model returns 0xA5 → nvramOE low exactly in sequence 0–2, vramAddr = 0x0123, vidData = 0xA5 with vidDataValid high during sequence 3.
- Push (0x1FFF, 0x3C) during active video → vramAddr = 0x1FFF, vramDataOut = 0x3C, nvramWE low only in sequence 5, vramDataOE high only in sequence 4–6, fifoLevel back to 0.
- Push 5 writes back-to-back with FIFO_DEPTH = 4, no slots elapsing → wrReady = 0 after the 4th, 5th ignored, fifoLevel = 4; drains one per slot in order.
- Blanking (vidActive = 0), 4 queued writes → with VRAM_ARB_BLANK_WRITE_EN: all written within 2 slots; without: 4 slots, nvramOE never asserted.
- Random vidActive/push traffic for 10k cycles → checker: never nvramOE & nvramWE both low; never vramDataOE with nvramOE low; write order preserved.
